// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module      : async_fifo_pkg
// Description : Shared pointer helpers for the async FIFO write/read sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    localparam int DEF_PTR_W = 8;
    localparam int WRAP_BIT  = DEF_PTR_W - 1;

    function automatic logic ptr_wrap(input logic [31:0] p, input int n);
        return p[n-1];
    endfunction

    function automatic logic [31:0] ptr_idx(input logic [31:0] p, input int n);
        logic [31:0] mask;
        mask = (32'd1 << (n - 1)) - 32'd1;
        return p & mask;
    endfunction

    // Index space is 0..depth-1 per lap, so a lap difference adds depth, not 2**(n-1).
    function automatic logic [31:0] ptr_level(input logic [31:0] wp, input logic [31:0] rp,
                                              input int depth, input int n);
        logic [31:0] wi;
        logic [31:0] ri;
        wi = ptr_idx(wp, n);
        ri = ptr_idx(rp, n);
        if (ptr_wrap(wp, n) == ptr_wrap(rp, n))
            return wi - ri;
        else
            return 32'(depth) - ri + wi;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_level_calc.sv
// ============================================================================
// Module      : fifo_level_calc
// Description : Combinational fill level and full detection from two pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_level_calc
    import async_fifo_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 90
) (
    input  logic [N-1:0] i_wr_ptr,
    input  logic [N-1:0] i_rd_ptr,
    output logic [N-1:0] o_fill_level,
    output logic         o_full
);

    always_comb begin
        o_fill_level = N'(ptr_level(32'(i_wr_ptr), 32'(i_rd_ptr), DEPTH, N));
        o_full       = (i_wr_ptr[N-1] != i_rd_ptr[N-1]) &&
                       (i_wr_ptr[N-2:0] == i_rd_ptr[N-2:0]);
    end

endmodule

`default_nettype wire

// File: rtl/wrptr_ctrl.sv
// ============================================================================
// Module      : wrptr_ctrl
// Description : Async FIFO write-pointer controller with full/level/ack/overflow.
//               Optional WR_OVERFLOW_CNT_EN adds a saturating ovf_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int N         = 8,
    parameter int DEPTH     = 90,
    parameter int AF_THRESH = 80
) (
    input  logic         wr_clk,
    input  logic         wr_rst,
    input  logic         wr_en,
    input  logic [N-1:0] rd_ptr,
    output logic [N-1:0] wr_ptr,
    output logic [N-2:0] wr_addr,
    output logic         wr_mem_en,
    output logic         fifo_Full,
    output logic         almost_full,
    output logic [N-1:0] fill_level,
    output logic         wr_ack,
    output logic         overflow
`ifdef WR_OVERFLOW_CNT_EN
    ,
    output logic [15:0]  ovf_count
`endif
);

    localparam logic [N-2:0] c_LAST_IDX = (N-1)'(DEPTH - 1);
    localparam logic [N-1:0] c_AF_LVL   = N'(AF_THRESH);

    logic [N-1:0] r_ptr;
    logic         r_ack;
    logic         r_ovf;
    logic         w_full;
    logic [N-1:0] w_level;
    logic         w_accept;
    logic         w_reject;

    fifo_level_calc #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_level (
        .i_wr_ptr     (r_ptr),
        .i_rd_ptr     (rd_ptr),
        .o_fill_level (w_level),
        .o_full       (w_full)
    );

    assign w_accept = wr_en & ~w_full;
    assign w_reject = wr_en & w_full;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_ptr <= '0;
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_reject)
                r_ovf <= 1'b1;
            // Non-power-of-two depth: index wraps at DEPTH-1, toggling the lap bit.
            if (w_accept) begin
                if (r_ptr[N-2:0] == c_LAST_IDX)
                    r_ptr <= {~r_ptr[N-1], {(N-1){1'b0}}};
                else
                    r_ptr <= {r_ptr[N-1], r_ptr[N-2:0] + {{(N-2){1'b0}}, 1'b1}};
            end
        end
    end

`ifdef WR_OVERFLOW_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge wr_clk) begin
        if (wr_rst)
            r_ovf_cnt <= '0;
        else if (w_reject && (r_ovf_cnt != 16'hFFFF))
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end

    assign ovf_count = r_ovf_cnt;
`endif

    assign wr_ptr      = r_ptr;
    assign wr_addr     = r_ptr[N-2:0];
    assign wr_mem_en   = w_accept;
    assign fifo_Full   = w_full;
    assign fill_level  = w_level;
    assign almost_full = (w_level >= c_AF_LVL);
    assign wr_ack      = r_ack;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wrptr_ctrl.sv
// ============================================================================
// Module      : tb_wrptr_ctrl
// Description : Self-checking bench for wrptr_ctrl (vector table + ack scoreboard).
//               Exercises ovf_count when WR_OVERFLOW_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrptr_ctrl;

    localparam int N     = 8;
    localparam int DEPTH = 90;
    localparam int AF    = 80;
    localparam int LAPS  = 2 * DEPTH;

    logic         wr_clk = 1'b0;
    logic         wr_rst;
    logic         wr_en;
    logic [N-1:0] rd_ptr;
    logic [N-1:0] wr_ptr;
    logic [N-2:0] wr_addr;
    logic         wr_mem_en;
    logic         fifo_Full;
    logic         almost_full;
    logic [N-1:0] fill_level;
    logic         wr_ack;
    logic         overflow;
`ifdef WR_OVERFLOW_CNT_EN
    logic [15:0]  ovf_count;
`endif

    wrptr_ctrl #(.N(N), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .wr_en       (wr_en),
        .rd_ptr      (rd_ptr),
        .wr_ptr      (wr_ptr),
        .wr_addr     (wr_addr),
        .wr_mem_en   (wr_mem_en),
        .fifo_Full   (fifo_Full),
        .almost_full (almost_full),
        .fill_level  (fill_level),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
`ifdef WR_OVERFLOW_CNT_EN
        ,
        .ovf_count   (ovf_count)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: writes and reads counted modulo two laps; pointer encoding derived from the count.
    int m_w   = 0;
    int m_r   = 0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;
    bit ack_q[$];

    typedef struct {
        bit          en;
        int          rc;
        logic [7:0]  exp_ptr;
        int          exp_lvl;
        bit          exp_ack;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [7:0] enc(input int c);
        return 8'(((c >= DEPTH) ? 128 : 0) + (c % DEPTH));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic do_reset(input bit en);
        wr_rst = 1'b1;
        wr_en  = en;
        rd_ptr = '0;
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;
        wr_en  = 1'b0;
        m_w = 0; m_r = 0; m_ovf = 1'b0; m_cnt = 0;
        ack_q.delete();
    endtask

    // One clock: drive inputs, check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic cycle(input bit en, input int rc);
        int  lvl;
        bit  full;
        bit  acc;
        wr_en  = en;
        m_r    = rc;
        rd_ptr = enc(rc);
        @(negedge wr_clk);
        lvl  = (m_w - m_r + LAPS) % LAPS;
        full = (lvl == DEPTH);
        acc  = en && !full;
        chk("fill_level", int'(fill_level), lvl);
        chk("fifo_Full", int'(fifo_Full), int'(full));
        chk("almost_full", int'(almost_full), int'(lvl >= AF));
        chk("wr_mem_en", int'(wr_mem_en), int'(acc));
        chk("wr_addr", int'(wr_addr), m_w % DEPTH);
        ack_q.push_back(acc);
        if (acc) m_w = (m_w + 1) % LAPS;
        if (en && full) begin
            m_ovf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        @(posedge wr_clk);
        #1;
        chk("wr_ack", int'(wr_ack), int'(ack_q.pop_front()));
        chk("wr_ptr", int'(wr_ptr), int'(enc(m_w)));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_af;

        wr_en  = 1'b0;
        wr_rst = 1'b0;
        rd_ptr = '0;
        @(posedge wr_clk);
        #1;
        do_reset(1'b0);
        chk("rst_wr_ptr", int'(wr_ptr), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_overflow", int'(overflow), 0);
        #4;
        chk("rst_fill_level", int'(fill_level), 0);
        chk("rst_full", int'(fifo_Full), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        @(posedge wr_clk);
        #1;

        // Five writes, an idle cycle, then a write alongside a two-entry read.
        tbl[0] = '{1'b1, 0, 8'h01, 1, 1'b1};
        tbl[1] = '{1'b1, 0, 8'h02, 2, 1'b1};
        tbl[2] = '{1'b1, 0, 8'h03, 3, 1'b1};
        tbl[3] = '{1'b1, 0, 8'h04, 4, 1'b1};
        tbl[4] = '{1'b1, 0, 8'h05, 5, 1'b1};
        tbl[5] = '{1'b0, 0, 8'h05, 5, 1'b0};
        tbl[6] = '{1'b1, 2, 8'h06, 4, 1'b1};
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].en, tbl[i].rc);
            chk("tbl_wr_ptr", int'(wr_ptr), int'(tbl[i].exp_ptr));
            chk("tbl_fill_level", int'(fill_level), tbl[i].exp_lvl);
            chk("tbl_wr_ack", int'(wr_ack), int'(tbl[i].exp_ack));
            chk("tbl_full", int'(fifo_Full), 0);
        end

        // Fill to full and watch almost_full rise.
        do_reset(1'b0);
        first_af = -1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 0);
            if (almost_full && first_af < 0) first_af = int'(fill_level);
        end
        chk("af_rise_level", first_af, AF);
        chk("full_wr_ptr", int'(wr_ptr), 8'h80);
        chk("full_flag", int'(fifo_Full), 1);
        chk("full_level", int'(fill_level), 90);
        cycle(1'b1, 0);
        chk("reject_wr_ptr", int'(wr_ptr), 8'h80);
        chk("reject_overflow", int'(overflow), 1);
        chk("reject_ack", int'(wr_ack), 0);

        // Read frees a slot in the same cycle as a write.
        cycle(1'b1, 1);
        chk("free_wr_ptr", int'(wr_ptr), 8'h81);
        chk("free_ack", int'(wr_ack), 1);
        chk("free_overflow_held", int'(overflow), 1);

        // Reset wins over a write; overflow clears.
        do_reset(1'b1);
        chk("rstw_ptr_a", int'(wr_ptr), 0);
        chk("rstw_overflow", int'(overflow), 0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 0);
        chk("pre_rst_ptr", int'(wr_ptr), 8'h10);
        do_reset(1'b1);
        chk("rstw_ptr_b", int'(wr_ptr), 0);
        chk("rstw_ack", int'(wr_ack), 0);

        // Index 89 -> wrap with reader at index 32.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 0);
        chk("idx89_ptr", int'(wr_ptr), 8'h59);
        cycle(1'b1, 32);
        chk("wrap_ptr", int'(wr_ptr), 8'h80);
        chk("wrap_level", int'(fill_level), 58);
        cycle(1'b0, 32);

`ifdef WR_OVERFLOW_CNT_EN
        do_reset(1'b0);
        chk("cnt_reset", int'(ovf_count), 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        chk("cnt_three", int'(ovf_count), 3);
        wr_en = 1'b1;
        repeat (65532) @(posedge wr_clk);
        #1;
        m_cnt = 65535;
        chk("cnt_sat", int'(ovf_count), 16'hFFFF);
        cycle(1'b1, 0);
        chk("cnt_sat_hold", int'(ovf_count), 16'hFFFF);
        chk("cnt_model", int'(ovf_count), m_cnt);
        chk("cnt_ptr_held", int'(wr_ptr), 8'h80);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
